sd_dat_tx_serializer: RTL and testbench

SD_DAT_TX_SERIALIZER -- requirements
Module: sd_dat_tx_serializer

---
 rtl/sd_dat_pkg.sv | 26 ++
 rtl/sd_crc16_bit.sv | 33 +++
 rtl/sd_dat_tx_serializer.sv | 181 ++++++++++++++++++
 tb/tb_sd_dat_tx_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT transmit path.
// State encoding, CRC polynomial, frame nibbles and block size limits.
package sd_dat_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      STALL,
      CRC,
      END
   } state_e;

   localparam logic [15:0] CRC16_POLY      = 16'h1021;
   localparam logic [3:0]  START_NIB       = 4'h0;
   localparam logic [3:0]  END_NIB         = 4'hF;
   localparam int          MAX_BLOCK_BYTES = 2048;

   // Legal sizes are whole 32-bit words, non-zero, up to the max.
   function automatic logic size_ok(input logic [11:0] s);
      return (s != 12'd0) && (s[1:0] == 2'b00) &&
             (s <= 12'(MAX_BLOCK_BYTES));
   endfunction

endpackage

// File: rtl/sd_crc16_bit.sv
// Serial CRC16 (x^16+x^12+x^5+1) for one DAT line.
// One bit per enabled cycle; clear returns to the zero seed.
module sd_crc16_bit
   import sd_dat_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   always_comb begin
      fb    = din_i ^ crc_q[15];
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         crc_q <= '0;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_tx_serializer.sv
// SD 4-bit DAT block transmitter: start bit, FIFO words, per-line CRC16, end bit.
// Prefetches the next word on nibble 6 so consecutive words go out gapless.
module sd_dat_tx_serializer
   import sd_dat_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] block_size,
   input  logic [31:0] fifo_data,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [3:0]  dat_out,
   output logic        dat_oe,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [11:0] bytes_q, bytes_d;
   logic [31:0] sh_q, sh_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pf_q, pf_d;
   logic [3:0]  hold_q, hold_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        crc_en;
   logic        crc_clr;
   logic [15:0] crc_w [4];
   logic [3:0]  crc_nib;

   for (genvar g = 0; g < 4; g++) begin : g_crc
      sd_crc16_bit u_crc (
         .clk   (clk),
         .reset (reset),
         .clr_i (crc_clr),
         .en_i  (crc_en),
         .din_i (dat_out[g]),
         .crc_o (crc_w[g])
      );
   end

   always_comb begin
      crc_nib = '0;
      for (int i = 0; i < 4; i++) begin
         crc_nib[i] = crc_w[i][4'd15 - cnt_q];
      end
   end

   always_comb begin
      state_d    = state_q;
      bytes_d    = bytes_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      pf_d       = pf_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      fifo_rd_en = 1'b0;
      dat_out    = END_NIB;
      dat_oe     = 1'b0;
      stall      = 1'b0;
      crc_en     = 1'b0;
      crc_clr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (size_ok(block_size)) begin
                  state_d = FETCH;
                  bytes_d = block_size;
                  cnt_d   = '0;
                  pf_d    = 1'b0;
                  crc_clr = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            dat_oe  = 1'b1;
            dat_out = START_NIB;
            sh_d    = fifo_data;
            bytes_d = bytes_q - 12'd4;
            cnt_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            dat_oe  = 1'b1;
            dat_out = sh_q[31:28];
            hold_d  = sh_q[31:28];
            crc_en  = 1'b1;
            sh_d    = {sh_q[27:0], 4'h0};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd6 && bytes_q != 12'd0 && !fifo_empty) begin
               fifo_rd_en = 1'b1;
               pf_d       = 1'b1;
            end
            if (cnt_q == 4'd7) begin
               cnt_d = '0;
               if (bytes_q == 12'd0) begin
                  state_d = CRC;
               end else if (pf_q) begin
                  sh_d    = fifo_data;
                  bytes_d = bytes_q - 12'd4;
                  pf_d    = 1'b0;
               end else begin
                  state_d = STALL;
               end
            end
         end
         STALL: begin
            dat_oe  = 1'b1;
            dat_out = hold_q;
            stall   = 1'b1;
            // pf_q marks that the read was issued; its data is valid now.
            if (pf_q) begin
               sh_d    = fifo_data;
               bytes_d = bytes_q - 12'd4;
               pf_d    = 1'b0;
               state_d = DATA;
            end else if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               pf_d       = 1'b1;
            end
         end
         CRC: begin
            dat_oe  = 1'b1;
            dat_out = crc_nib;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = END;
            end
         end
         END: begin
            dat_oe  = 1'b1;
            dat_out = END_NIB;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         bytes_q <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         pf_q    <= 1'b0;
         hold_q  <= END_NIB;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bytes_q <= bytes_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         pf_q    <= pf_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_sd_dat_tx_serializer.sv
// Directed and random frames against a division-based CRC frame model.
// FIFO, start and reset are driven just after each rising edge.
module tb_sd_dat_tx_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] block_size = '0;
   logic [31:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd_en;
   logic [3:0]  dat_out;
   logic        dat_oe;
   logic        busy;
   logic        stall;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   sd_dat_tx_serializer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .block_size (block_size),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .dat_out    (dat_out),
      .dat_oe     (dat_oe),
      .busy       (busy),
      .stall      (stall),
      .done       (done),
      .err        (err)
   );

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] words[$];
   logic [31:0] fq[$];
   logic [3:0]  obs[$];
   logic [3:0]  refq[$];
   logic [3:0]  exp_nib[$];
   logic [3:0]  dn[$];
   int oe_cyc, stall_cyc, rd_cnt, done_cnt, err_cnt, busy_cyc;
   int first_oe, done_at;

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Remainder of M(x)*x^16 divided by G(x), by long division.
   function automatic logic [15:0] crc_line(input int ln);
      bit          m[$];
      logic [16:0] g;
      logic [15:0] r;
      g = 17'h11021;
      r = '0;
      foreach (dn[j]) m.push_back(dn[j][ln]);
      repeat (16) m.push_back(1'b0);
      for (int j = 0; j + 16 < m.size(); j++) begin
         if (m[j]) begin
            for (int t = 0; t < 17; t++) m[j+t] = m[j+t] ^ g[16-t];
         end
      end
      for (int t = 0; t < 16; t++) r[15-t] = m[m.size()-16+t];
      return r;
   endfunction

   task automatic build_exp();
      logic [15:0] c[4];
      dn.delete();
      exp_nib.delete();
      foreach (words[w]) begin
         for (int k = 0; k < 8; k++) dn.push_back(words[w][31-4*k -: 4]);
      end
      exp_nib.push_back(4'h0);
      foreach (dn[j]) exp_nib.push_back(dn[j]);
      for (int i = 0; i < 4; i++) c[i] = crc_line(i);
      for (int k = 0; k < 16; k++) begin
         exp_nib.push_back({c[3][15-k], c[2][15-k], c[1][15-k], c[0][15-k]});
      end
      exp_nib.push_back(4'hF);
   endtask

   task automatic fill_rand(input logic [11:0] bs);
      words.delete();
      repeat (int'(bs) / 4) words.push_back($urandom);
   endtask

   task automatic run(input logic [11:0] bs, input int abort_nib,
                      input int dup_cyc, input int wh_len, input bit rnd);
      int       limit, abort_c, cy;
      bit       fin, rd_pend;
      logic [3:0] prev;
      limit = 6 * int'(bs) + 200;
      abort_c = -1; fin = 0; rd_pend = 0; prev = 4'hF;
      fq = words; obs.delete();
      oe_cyc = 0; stall_cyc = 0; rd_cnt = 0; done_cnt = 0;
      err_cnt = 0; busy_cyc = 0; first_oe = -1; done_at = -1;
      block_size = bs;
      start = 1'b1;
      fifo_empty = (fq.size() == 0);
      for (int c = 0; c < limit && !fin; c++) begin
         @(negedge clk);
         rd_pend = fifo_rd_en;
         if (fifo_rd_en) rd_cnt++;
         if (err) err_cnt++;
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (stall) begin
            stall_cyc++;
            chk("stall_hold", dat_out, prev);
         end else if (dat_oe) begin
            oe_cyc++;
            if (first_oe < 0) first_oe = c;
            obs.push_back(dat_out);
            prev = dat_out;
         end
         if (abort_c >= 0 && c == abort_c + 1) begin
            chk("abort_oe", dat_oe, 1'b0);
            chk("abort_dat", dat_out, 4'hF);
            chk("abort_busy", busy, 1'b0);
            chk("abort_rd", fifo_rd_en, 1'b0);
            chk("abort_stall", stall, 1'b0);
         end
         if (abort_nib >= 0 && abort_c < 0 && obs.size() == abort_nib + 2) begin
            reset = 1'b1;
            abort_c = c;
         end
         if ((done_at >= 0 && c >= done_at + 2) ||
             (abort_c >= 0 && c >= abort_c + 20)) fin = 1;
         @(posedge clk);
         #1;
         cy = c + 1;
         reset = 1'b0;
         start = (cy == dup_cyc);
         if (cy == dup_cyc) block_size = 12'd6;
         if (abort_c >= 0) begin
            fq.delete();
            rd_pend = 0;
         end
         if (rd_pend) begin
            if (fq.size() > 0) fifo_data = fq.pop_front();
            else chk("fifo_underflow", 1, 0);
         end
         fifo_empty = (fq.size() == 0) ||
                      (wh_len > 0 && cy >= 9 && cy < 9 + wh_len) ||
                      (rnd && $urandom_range(0, 3) == 0);
      end
      if (!fin) chk("run_timeout", 0, 1);
   endtask

   task automatic check_frame(input string tag, input logic [11:0] bs);
      build_exp();
      chk({tag, "_len"}, obs.size(), exp_nib.size());
      for (int j = 0; j < exp_nib.size() && j < obs.size(); j++) begin
         chk({tag, "_nib"}, obs[j], exp_nib[j]);
      end
      chk({tag, "_oe_cycles"}, oe_cyc, 2 * int'(bs) + 18);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_rd_cnt"}, rd_cnt, int'(bs) / 4);
      chk({tag, "_fifo_left"}, fq.size(), 0);
   endtask

   initial begin
      logic [11:0] bad[4];
      logic [11:0] rs;
      bad = '{12'd6, 12'd0, 12'd2052, 12'd4095};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_oe", dat_oe, 1'b0);
      chk("rst_dat", dat_out, 4'hF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd", fifo_rd_en, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      words.delete();
      words.push_back(32'h0FCB01AA);
      run(12'd4, -1, -1, 0, 1'b0);
      check_frame("b4", 12'd4);
      chk("b4_first_start", first_oe, 2);
      chk("b4_done_at", done_at, 28);
      chk("b4_oe", oe_cyc, 26);
      chk("b4_busy_cycles", busy_cyc, 27);
      chk("b4_nib_F", obs[2], 4'hF);

      words.delete();
      repeat (128) words.push_back(32'h0);
      run(12'd512, -1, -1, 0, 1'b0);
      check_frame("zero512", 12'd512);
      chk("zero512_rd", rd_cnt, 128);
      chk("zero512_oe", oe_cyc, 1042);
      chk("zero512_stall", stall_cyc, 0);
      chk("zero512_end", obs[obs.size()-1], 4'hF);
      chk("zero512_crc0", obs[obs.size()-2], 4'h0);

      fill_rand(12'd8);
      run(12'd8, -1, -1, 0, 1'b0);
      check_frame("b8_clean", 12'd8);
      refq = obs;
      run(12'd8, -1, -1, 5, 1'b0);
      check_frame("b8_stall", 12'd8);
      chk("b8_stall_cycles", stall_cyc, 5);
      chk("b8_same_as_clean", obs == refq, 1'b1);

      foreach (bad[i]) begin
         block_size = bad[i];
         start = 1'b1;
         @(negedge clk);
         chk("bad_err_c0", err, 1'b0);
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         chk("bad_err_c1", err, 1'b1);
         chk("bad_busy_c1", busy, 1'b0);
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("bad_err_c2", err, 1'b0);
         chk("bad_busy_c2", busy, 1'b0);
         chk("bad_oe_c2", dat_oe, 1'b0);
         @(posedge clk);
         #1;
      end

      fill_rand(12'd4);
      run(12'd4, -1, 5, 0, 1'b0);
      check_frame("dup_start", 12'd4);

      fill_rand(12'd512);
      run(12'd512, 300, -1, 0, 1'b0);
      chk("abort_no_done", done_cnt, 0);
      fill_rand(12'd64);
      run(12'd64, -1, -1, 0, 1'b0);
      check_frame("after_abort", 12'd64);

      fill_rand(12'd2048);
      run(12'd2048, -1, -1, 0, 1'b0);
      check_frame("max2048", 12'd2048);

      for (int k = 0; k < 3; k++) begin
         rs = 12'($urandom_range(1, 64) * 4);
         fill_rand(rs);
         run(rs, -1, -1, 0, 1'b1);
         check_frame("rand_gaps", rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
